// File: rtl/pc_trace_uart.sv
// Streams each new program-counter value as an ASCII hex line ("XXXXXXXX\r\n") over an 8N1 UART.
// Define PC_TRACE_TRAP_EN to emit a '!'-prefixed line on a trap rising edge, then halt until reset.
module pc_trace_uart #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pc,
   input  logic        trap,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef PC_TRACE_TRAP_EN
   typedef enum logic [1:0] {IDLE, SEND, HALT} state_e;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

   state_e             state_q, state_d;
   logic [31:0]        last_pc_q, last_pc_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        frame_q, frame_d;
   logic [3:0]         byte_idx_q, byte_idx_d;
   logic [3:0]         bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]   baud_q, baud_d;
   logic               tx_q, tx_d;
   logic [7:0]         drop_q, drop_d;

   logic [3:0]         last_byte;
   logic [2:0]         digit_sel;
   logic [3:0]         nibble;
   logic [7:0]         cur_byte;
   logic               start_trap;

`ifdef PC_TRACE_TRAP_EN
   logic               trap_q, trap_d;
   logic               pend_q, pend_d;
   logic               bang_q, bang_d;
   logic               trap_rise;
`else
   logic               unused_trap;
   assign unused_trap = trap;
`endif

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte currently on the wire; a trap line shifts the digits one slot right of the '!'.
   always_comb begin
      last_byte = 4'd9;
      digit_sel = byte_idx_q[2:0];
`ifdef PC_TRACE_TRAP_EN
      if (bang_q) begin
         last_byte = 4'd10;
         digit_sel = 3'(byte_idx_q - 4'd1);
      end
`endif
      nibble = frame_q[5'd28 - {digit_sel, 2'b00} +: 4];
      if (byte_idx_q == last_byte)
         cur_byte = 8'h0A;
      else if (byte_idx_q == last_byte - 4'd1)
         cur_byte = 8'h0D;
      else
         cur_byte = hex_char(nibble);
`ifdef PC_TRACE_TRAP_EN
      if (bang_q && byte_idx_q == 4'd0)
         cur_byte = 8'h21;
`endif
   end

   always_comb begin
      state_d    = state_q;
      last_pc_d  = last_pc_q;
      pc_d       = pc;
      frame_d    = frame_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      baud_d     = baud_q;
      tx_d       = tx_q;
      drop_d     = drop_q;
      busy       = (state_q == SEND);
`ifdef PC_TRACE_TRAP_EN
      trap_d     = trap;
      bang_d     = bang_q;
      trap_rise  = trap & ~trap_q;
      pend_d     = pend_q | trap_rise;
      start_trap = pend_q | trap_rise;
`else
      start_trap = 1'b0;
`endif

      if (busy && pc != pc_q && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (start_trap || pc != last_pc_q) begin
               frame_d    = pc;
               last_pc_d  = pc;
               state_d    = SEND;
               tx_d       = 1'b0;
               baud_d     = '0;
               bit_idx_d  = '0;
               byte_idx_d = '0;
`ifdef PC_TRACE_TRAP_EN
               bang_d     = start_trap;
               pend_d     = 1'b0;
`endif
            end
         end
         SEND: begin
            if (baud_q == CNT_LAST) begin
               baud_d = '0;
               if (bit_idx_q == 4'd9) begin
                  if (byte_idx_q == last_byte) begin
                     tx_d = 1'b1;
`ifdef PC_TRACE_TRAP_EN
                     state_d = bang_q ? HALT : IDLE;
`else
                     state_d = IDLE;
`endif
                  end else begin
                     byte_idx_d = byte_idx_q + 4'd1;
                     bit_idx_d  = '0;
                     tx_d       = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
`ifdef PC_TRACE_TRAP_EN
         HALT: tx_d = 1'b1;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         last_pc_q  <= '0;
         pc_q       <= '0;
         frame_q    <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         baud_q     <= '0;
         tx_q       <= 1'b1;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_pc_q  <= last_pc_d;
         pc_q       <= pc_d;
         frame_q    <= frame_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         baud_q     <= baud_d;
         tx_q       <= tx_d;
         drop_q     <= drop_d;
      end
   end

`ifdef PC_TRACE_TRAP_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         trap_q <= 1'b0;
         pend_q <= 1'b0;
         bang_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
         pend_q <= pend_d;
         bang_q <= bang_d;
      end
   end
`endif

   assign tx       = tx_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pc_trace_uart.sv
// Directed bench for pc_trace_uart at CLKS_PER_BIT = 4: decodes tx and compares against hand-written lines.
module tb_pc_trace_uart;
   localparam int unsigned CPB = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] pc = '0;
   logic        trap = 1'b0;
   logic        tx;
   logic        busy;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] digits;
      logic [7:0]  drop;
   } vec_t;
   vec_t tbl[5];

   logic [87:0] line;
   bit          ok;
   int          bc;

   pc_trace_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .resetn(resetn), .pc(pc), .trap(trap),
      .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [87:0] got, input logic [87:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic recv_byte(output logic [7:0] b, output bit good);
      good = 1'b0;
      b = '0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            good = 1'b1;
            break;
         end
      end
      if (!good) return;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) good = 1'b0;
   endtask

   task automatic recv_line(input int nbytes, output logic [87:0] l, output bit good);
      logic [7:0] b;
      l = '0;
      good = 1'b1;
      for (int i = 0; i < nbytes; i++) begin
         recv_byte(b, good);
         if (!good) return;
         l = {l[79:0], b};
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(name, 88'(busy), 88'd0);
   endtask

   task automatic quiet(input int cycles, input string name);
      int bad = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check(name, 88'(bad), 88'd0);
   endtask

   initial begin
      tbl[0] = '{32'hDEADBEEF, "DEADBEEF", 8'd3};
      tbl[1] = '{32'h0123ABCD, "0123ABCD", 8'd3};
      tbl[2] = '{32'hFFFFFFFF, "FFFFFFFF", 8'd3};
      tbl[3] = '{32'h00000000, "00000000", 8'd3};
      tbl[4] = '{32'h9A5F0E71, "9A5F0E71", 8'd3};

      repeat (3) @(negedge clk);
      check("reset_tx", 88'(tx), 88'd1);
      check("reset_busy", 88'(busy), 88'd0);
      check("reset_drop", 88'(drop_cnt), 88'd0);
      resetn = 1'b1;
      quiet(1000, "idle_pc0");

      // First line with three pc steps landing mid-frame.
      pc = 32'h00000104;
      bc = 0;
      fork
         recv_line(10, line, ok);
         begin
            for (int n = 0; n < 1000; n++) begin
               @(negedge clk);
               if (busy === 1'b1) bc++;
               else if (bc > 0) break;
            end
         end
         begin
            repeat (50) @(negedge clk); pc = 32'h00000108;
            repeat (50) @(negedge clk); pc = 32'h0000010C;
            repeat (50) @(negedge clk); pc = 32'h00000110;
         end
      join
      check("line_104_ok", 88'(ok), 88'd1);
      check("line_104", line, {8'h00, "00000104", 16'h0D0A});
      check("busy_len", 88'(bc), 88'd400);
      check("drop_3", 88'(drop_cnt), 88'd3);
      recv_line(10, line, ok);
      check("line_110", line, {8'h00, "00000110", 16'h0D0A});
      wait_idle("idle_after_110");

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pc = tbl[i].pc;
         recv_line(10, line, ok);
         check($sformatf("tbl%0d_line", i), line, {8'h00, tbl[i].digits, 16'h0D0A});
         wait_idle($sformatf("tbl%0d_idle", i));
         check($sformatf("tbl%0d_drop", i), 88'(drop_cnt), 88'(tbl[i].drop));
      end

      // Drop counter saturation; 350 toggles bring pc back to the sent value.
      @(negedge clk);
      pc = 32'h00000200;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 101) check("drop_103", 88'(drop_cnt), 88'd103);
         pc = pc ^ 32'h1;
      end
      @(negedge clk);
      check("drop_sat", 88'(drop_cnt), 88'd255);
      for (int j = 0; j < 50; j++) begin
         pc = pc ^ 32'h1;
         @(negedge clk);
      end
      check("drop_hold", 88'(drop_cnt), 88'd255);
      wait_idle("idle_after_toggle");
      quiet(100, "no_queued_line");

      // Reset at frame cycle 150 (byte 3, data bit 6 of '0' = 0).
      pc = 32'h00000300;
      repeat (151) @(negedge clk);
      check("mid_tx_low", 88'(tx), 88'd0);
      check("mid_busy", 88'(busy), 88'd1);
      #1 resetn = 1'b0;
      #1;
      check("async_tx", 88'(tx), 88'd1);
      check("async_busy", 88'(busy), 88'd0);
      check("async_drop", 88'(drop_cnt), 88'd0);
      pc = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      quiet(500, "no_bytes_after_reset");

`ifdef PC_TRACE_TRAP_EN
      pc = 32'h00000080;
      trap = 1'b1;
      recv_line(11, line, ok);
      check("trap_line", line, {"!00000080", 16'h0D0A});
      wait_idle("trap_idle");
      trap = 1'b0;
      pc = 32'h00000084;
      quiet(200, "halt_quiet_84");
      pc = 32'h00000088;
      quiet(200, "halt_quiet_88");
`else
      pc = 32'h00000080;
      trap = 1'b1;
      recv_line(10, line, ok);
      check("notrap_line_80", line, {8'h00, "00000080", 16'h0D0A});
      wait_idle("notrap_idle_80");
      trap = 1'b0;
      @(negedge clk);
      pc = 32'h00000084;
      recv_line(10, line, ok);
      check("notrap_line_84", line, {8'h00, "00000084", 16'h0D0A});
      wait_idle("notrap_idle_84");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
